// File: rtl/id_hazard_tracker.sv
// ID-stage hazard tracker: tracks downstream destination tags and picks the operand source for branch/JALR.
// Latency: selects and stall_id are combinational this cycle; tag slots and stall_cycles update on the clk rising edge.
// Backpressure: stall_ext freezes all slots; stall_id holds PC and IF/ID and puts a bubble into slot 0.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid, branch_id, jalr_id    ID instruction qualifiers
//   rs1_id, rs2_id, rd_id           ID register numbers
//   reg_write_id, mem_read_id       ID producer attributes (writes rd, is a load)
//   flush_id                        ID instruction killed; never enters slot 0
//   stall_ext                       global pipeline freeze
//   rs1_fwd_sel, rs2_fwd_sel        0 = register file, s = forward from slot s-1
//   stall_id                        stall ID / bubble into EX
//   stall_cycles                    saturating count of stalled cycles
module id_hazard_tracker #(
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             branch_id,
  input  logic             jalr_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic             reg_write_id,
  input  logic             mem_read_id,
  input  logic             flush_id,
  input  logic             stall_ext,
  output logic [SEL_W-1:0] rs1_fwd_sel,
  output logic [SEL_W-1:0] rs2_fwd_sel,
  output logic             stall_id,
  output logic [15:0]      stall_cycles
);

  // Tag slots: index 0 is the youngest (EX), DEPTH-1 the oldest.
  logic [DEPTH-1:0] slot_vld;
  logic [DEPTH-1:0] slot_wr;
  logic [DEPTH-1:0] slot_ld;
  logic [4:0]       slot_rd [DEPTH];

  logic rs1_need;
  logic rs2_need;
  logic rs1_req;
  logic rs2_req;
  logic [DEPTH-1:0] slot_ready;

  assign rs1_need = id_valid & (branch_id | jalr_id) & (rs1_id != 5'd0);
  assign rs2_need = id_valid & branch_id & (rs2_id != 5'd0);

  // A slot's result is forwardable once it has travelled far enough for its kind.
  always_comb begin
    slot_ready = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot_ready[k] = slot_ld[k] ? (k >= LOAD_READY) : (k >= ALU_READY);
    end
  end

  // Scan oldest to youngest so the youngest match overwrites any older one;
  // an unready youngest match therefore hides a ready older one.
  always_comb begin
    rs1_fwd_sel = '0;
    rs2_fwd_sel = '0;
    rs1_req     = 1'b0;
    rs2_req     = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rs1_need && slot_vld[k] && slot_wr[k] && (slot_rd[k] == rs1_id)) begin
        rs1_fwd_sel = slot_ready[k] ? SEL_W'(k + 1) : '0;
        rs1_req     = ~slot_ready[k];
      end
      if (rs2_need && slot_vld[k] && slot_wr[k] && (slot_rd[k] == rs2_id)) begin
        rs2_fwd_sel = slot_ready[k] ? SEL_W'(k + 1) : '0;
        rs2_req     = ~slot_ready[k];
      end
    end
  end

  // A flushed instruction never waits for its operands.
  assign stall_id = (rs1_req | rs2_req) & ~flush_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld <= '0;
      slot_wr  <= '0;
      slot_ld  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_rd[k] <= 5'd0;
      end
    end else if (!stall_ext) begin
      for (int k = 1; k < DEPTH; k++) begin
        slot_vld[k] <= slot_vld[k-1];
        slot_wr[k]  <= slot_wr[k-1];
        slot_ld[k]  <= slot_ld[k-1];
        slot_rd[k]  <= slot_rd[k-1];
      end
      slot_vld[0] <= id_valid & ~stall_id & ~flush_id;
      slot_wr[0]  <= reg_write_id;
      slot_ld[0]  <= mem_read_id;
      slot_rd[0]  <= rd_id;
    end
  end

  // Counts stalled cycles even while the pipe is externally frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 16'd0;
    end else if (stall_id && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule
